// File: rtl/me_seq_ctrl.sv
// Pass sequencer for the full-search motion estimation datapath: clears and steps the
// address generator, then emits latency-aligned valid and first/last markers for the PE array.
module me_seq_ctrl #(
  parameter int unsigned ADDR_SW  = 12,
  parameter int unsigned ADDR_TB  = 8,
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned PIPE_LAT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic hold,
  output logic busy,
  output logic done,
  output logic clr,
  output logic en_tb,
  output logic en_sw,
  output logic tb_valid,
  output logic sw_valid,
  output logic sw_first,
  output logic sw_last
);

  localparam int unsigned TB_LEN = 2 ** ADDR_TB;
  localparam logic [ADDR_SW-1:0] TB_LAST    = ADDR_SW'(TB_LEN - 1);
  localparam logic [ADDR_SW-1:0] SW_LAST    = '1;
  localparam logic [ADDR_SW-1:0] DRAIN_LAST = ADDR_SW'(MEM_LAT + PIPE_LAT - 1);

  typedef enum logic [2:0] {
    IDLE, CLR, LOAD_TB, LOAD_SW, DRAIN, DONE
  } state_e;

  typedef struct packed {
    logic tb;
    logic sw;
    logic first;
    logic last;
  } tap_t;

  state_e             state_q, state_d;
  logic [ADDR_SW-1:0] count_q, count_d;
  tap_t               tap_d;
  tap_t               pipe_q [MEM_LAT];

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    clr     = 1'b0;
    en_tb   = 1'b0;
    en_sw   = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: if (start) state_d = CLR;
      CLR: begin
        clr     = 1'b1;
        count_d = '0;
        state_d = LOAD_TB;
      end
      LOAD_TB: begin
        en_tb = ~hold;
        if (en_tb) begin
          if (count_q == TB_LAST) begin
            count_d = '0;
            state_d = LOAD_SW;
          end else begin
            count_d = count_q + ADDR_SW'(1);
          end
        end
      end
      LOAD_SW: begin
        en_sw = ~hold;
        if (en_sw) begin
          if (count_q == SW_LAST) begin
            count_d = '0;
            state_d = DRAIN;
          end else begin
            count_d = count_q + ADDR_SW'(1);
          end
        end
      end
      DRAIN: begin
        if (count_q == DRAIN_LAST) begin
          count_d = '0;
          state_d = DONE;
        end else begin
          count_d = count_q + ADDR_SW'(1);
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  always_comb begin
    tap_d.tb    = en_tb;
    tap_d.sw    = en_sw;
    tap_d.first = en_sw && (count_q == '0);
    tap_d.last  = en_sw && (count_q == SW_LAST);
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values,
  // independent of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // NOTE: the delay line is reset, not left to flush, so no stale valid or marker escapes
  // after an abandoned pass.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(MEM_LAT); i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= tap_d;
      for (int i = 1; i < int'(MEM_LAT); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tb_valid = pipe_q[MEM_LAT-1].tb;
  assign sw_valid = pipe_q[MEM_LAT-1].sw;
  assign sw_first = pipe_q[MEM_LAT-1].first;
  assign sw_last  = pipe_q[MEM_LAT-1].last;

endmodule

// File: tb/tb_me_seq_ctrl.sv
// Directed bench for me_seq_ctrl: default, MEM_LAT=3 and small-parameter instances,
// each pass recorded cycle by cycle (CLR cycle = 1) against hand-computed timing.
module tb_me_seq_ctrl;

  typedef struct packed {
    logic busy, done, clr, en_tb, en_sw, tb_valid, sw_valid, sw_first, sw_last;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       hold;
  logic [2:0] start_v;
  wire  [8:0] ob0, ob1, ob2;
  obs_t       cur;
  int         sel;

  int n_chk = 0;
  int n_fail = 0;

  // Recorded statistics of the last run
  int clr_cnt, clr_first, clr_last, tb_cnt, tb_first, tb_last, sw_cnt, sw_first_c, sw_last_c;
  int done_cnt, done_first, done_last, busy_cnt, busy_last, sf_cnt, sf_cyc, sl_cnt, sl_cyc;
  int tbv_cnt, swv_cnt, overlap, align_err, hold_strobe, post_rst_nz, busy_after_done;
  int h_lo [3], h_hi [3];
  bit eh_tb [16384];
  bit eh_sw [16384];

  always #5 clk = ~clk;

  me_seq_ctrl u_def (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .hold(hold),
    .busy(ob0[8]), .done(ob0[7]), .clr(ob0[6]), .en_tb(ob0[5]), .en_sw(ob0[4]),
    .tb_valid(ob0[3]), .sw_valid(ob0[2]), .sw_first(ob0[1]), .sw_last(ob0[0])
  );

  me_seq_ctrl #(.MEM_LAT(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .hold(hold),
    .busy(ob1[8]), .done(ob1[7]), .clr(ob1[6]), .en_tb(ob1[5]), .en_sw(ob1[4]),
    .tb_valid(ob1[3]), .sw_valid(ob1[2]), .sw_first(ob1[1]), .sw_last(ob1[0])
  );

  me_seq_ctrl #(.ADDR_TB(2), .ADDR_SW(3), .PIPE_LAT(0)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .hold(hold),
    .busy(ob2[8]), .done(ob2[7]), .clr(ob2[6]), .en_tb(ob2[5]), .en_sw(ob2[4]),
    .tb_valid(ob2[3]), .sw_valid(ob2[2]), .sw_first(ob2[1]), .sw_last(ob2[0])
  );

  always_comb begin
    case (sel)
      1:       cur = obs_t'(ob1);
      2:       cur = obs_t'(ob2);
      default: cur = obs_t'(ob0);
    endcase
  end

  function automatic bit in_hold(input int t);
    for (int i = 0; i < 3; i++) if (t >= h_lo[i] && t <= h_hi[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic do_reset();
    start_v = '0;
    hold    = 1'b0;
    rst_n   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic no_hold();
    for (int i = 0; i < 3; i++) begin h_lo[i] = -1; h_hi[i] = -2; end
  endtask

  // Start a pass on instance 'sel' (start sampled at the edge ending cycle 0) and record.
  task automatic run_pass(input int lat, input int max_cyc, input bit keep,
                          input int n_done, input int rst_at);
    bit exp_tbv, exp_swv;
    clr_cnt = 0; clr_first = -1; clr_last = -1; tb_cnt = 0; tb_first = -1; tb_last = -1;
    sw_cnt = 0; sw_first_c = -1; sw_last_c = -1; done_cnt = 0; done_first = -1; done_last = -1;
    busy_cnt = 0; busy_last = -1; sf_cnt = 0; sf_cyc = -1; sl_cnt = 0; sl_cyc = -1;
    tbv_cnt = 0; swv_cnt = 0; overlap = 0; align_err = 0; hold_strobe = 0; post_rst_nz = 0;
    busy_after_done = -1;
    for (int i = 0; i < 16384; i++) begin eh_tb[i] = 1'b0; eh_sw[i] = 1'b0; end
    @(posedge clk);
    #1 start_v[sel] = 1'b1;
    for (int t = 1; t <= max_cyc; t++) begin
      @(posedge clk);
      #1;
      start_v[sel] = keep;
      hold  = in_hold(t);
      rst_n = (t != rst_at);
      @(negedge clk);
      eh_tb[t] = cur.en_tb;
      eh_sw[t] = cur.en_sw;
      exp_tbv = (t - lat >= 1) ? eh_tb[t-lat] : 1'b0;
      exp_swv = (t - lat >= 1) ? eh_sw[t-lat] : 1'b0;
      if (cur.tb_valid !== exp_tbv || cur.sw_valid !== exp_swv) align_err++;
      if (cur.clr) begin clr_cnt++; if (clr_first < 0) clr_first = t; clr_last = t; end
      if (cur.en_tb) begin tb_cnt++; if (tb_first < 0) tb_first = t; tb_last = t; end
      if (cur.en_sw) begin sw_cnt++; if (sw_first_c < 0) sw_first_c = t; sw_last_c = t; end
      if (cur.done) begin done_cnt++; if (done_first < 0) done_first = t; done_last = t; end
      if (cur.busy) begin busy_cnt++; busy_last = t; end
      if (done_first >= 0 && t == done_first + 1) busy_after_done = cur.busy;
      if (cur.sw_first) begin sf_cnt++; if (sf_cyc < 0) sf_cyc = t; end
      if (cur.sw_last) begin sl_cnt++; if (sl_cyc < 0) sl_cyc = t; end
      if (cur.tb_valid) tbv_cnt++;
      if (cur.sw_valid) swv_cnt++;
      if ((cur.en_tb && cur.en_sw) || (cur.clr && (cur.en_tb || cur.en_sw))) overlap++;
      if (hold && (cur.en_tb || cur.en_sw)) hold_strobe++;
      if (rst_at > 0 && t > rst_at && cur !== '0) post_rst_nz++;
      if (done_cnt == n_done && t == done_last + 2) break;
    end
    start_v = '0;
    hold    = 1'b0;
    rst_n   = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_chk++; if (ob0 !== 9'h0) begin n_fail++; $display("FAIL reset_def: outputs %b expected 0", ob0); end
    n_chk++; if (ob1 !== 9'h0) begin n_fail++; $display("FAIL reset_lat3: outputs %b expected 0", ob1); end
    n_chk++; if (ob2 !== 9'h0) begin n_fail++; $display("FAIL reset_small: outputs %b expected 0", ob2); end
  endtask

  task automatic test_nominal();
    do_reset(); no_hold(); sel = 0;
    run_pass(1, 4600, 1'b0, 1, 0);
    n_chk++; if (clr_first !== 1 || clr_cnt !== 1) begin n_fail++; $display("FAIL nom_clr: cycle %0d count %0d expected 1/1", clr_first, clr_cnt); end
    n_chk++; if (tb_cnt !== 256 || tb_first !== 2 || tb_last !== 257) begin n_fail++; $display("FAIL nom_en_tb: %0d strobes %0d..%0d expected 256 2..257", tb_cnt, tb_first, tb_last); end
    n_chk++; if (sw_cnt !== 4096 || sw_first_c !== 258 || sw_last_c !== 4353) begin n_fail++; $display("FAIL nom_en_sw: %0d strobes %0d..%0d expected 4096 258..4353", sw_cnt, sw_first_c, sw_last_c); end
    n_chk++; if (done_first !== 4359 || done_cnt !== 1) begin n_fail++; $display("FAIL nom_done: cycle %0d count %0d expected 4359/1", done_first, done_cnt); end
    n_chk++; if (busy_cnt !== 4359 || busy_last !== 4359) begin n_fail++; $display("FAIL nom_busy: %0d cycles last %0d expected 4359/4359", busy_cnt, busy_last); end
    n_chk++; if (sf_cyc !== 259 || sf_cnt !== 1) begin n_fail++; $display("FAIL nom_sw_first: cycle %0d count %0d expected 259/1", sf_cyc, sf_cnt); end
    n_chk++; if (sl_cyc !== 4354 || sl_cnt !== 1) begin n_fail++; $display("FAIL nom_sw_last: cycle %0d count %0d expected 4354/1", sl_cyc, sl_cnt); end
    n_chk++; if (align_err !== 0 || tbv_cnt !== 256 || swv_cnt !== 4096) begin n_fail++; $display("FAIL nom_valid_align: err %0d tbv %0d swv %0d expected 0/256/4096", align_err, tbv_cnt, swv_cnt); end
    n_chk++; if (overlap !== 0) begin n_fail++; $display("FAIL nom_exclusive: %0d overlaps expected 0", overlap); end
  endtask

  task automatic test_mem_lat3();
    do_reset(); no_hold(); sel = 1;
    run_pass(3, 4600, 1'b0, 1, 0);
    n_chk++; if (done_first !== 4361) begin n_fail++; $display("FAIL lat3_done: cycle %0d expected 4361", done_first); end
    n_chk++; if (align_err !== 0 || tbv_cnt !== 256 || swv_cnt !== 4096) begin n_fail++; $display("FAIL lat3_valid_align: err %0d tbv %0d swv %0d expected 0/256/4096", align_err, tbv_cnt, swv_cnt); end
    n_chk++; if (sf_cyc !== 261 || sl_cyc !== 4356) begin n_fail++; $display("FAIL lat3_markers: first %0d last %0d expected 261/4356", sf_cyc, sl_cyc); end
  endtask

  task automatic test_hold();
    do_reset(); sel = 0;
    h_lo[0] = 100;  h_hi[0] = 109;
    h_lo[1] = 2000; h_hi[1] = 2006;
    h_lo[2] = 4372; h_hi[2] = 4374;
    run_pass(1, 4700, 1'b0, 1, 0);
    no_hold();
    n_chk++; if (tb_cnt !== 256 || tb_last !== 267) begin n_fail++; $display("FAIL hold_en_tb: %0d strobes last %0d expected 256/267", tb_cnt, tb_last); end
    n_chk++; if (sw_cnt !== 4096 || sw_last_c !== 4370) begin n_fail++; $display("FAIL hold_en_sw: %0d strobes last %0d expected 4096/4370", sw_cnt, sw_last_c); end
    n_chk++; if (done_first !== 4376) begin n_fail++; $display("FAIL hold_done: cycle %0d expected 4376", done_first); end
    n_chk++; if (hold_strobe !== 0 || align_err !== 0) begin n_fail++; $display("FAIL hold_suppress: strobes under hold %0d align err %0d expected 0/0", hold_strobe, align_err); end
    n_chk++; if (sl_cyc !== 4371) begin n_fail++; $display("FAIL hold_sw_last: cycle %0d expected 4371", sl_cyc); end
  endtask

  task automatic test_back_to_back();
    do_reset(); no_hold(); sel = 0;
    run_pass(1, 4600, 1'b1, 1, 0);
    n_chk++; if (done_first !== 4359) begin n_fail++; $display("FAIL b2b_done: cycle %0d expected 4359", done_first); end
    n_chk++; if (clr_cnt !== 2 || clr_last !== 4361) begin n_fail++; $display("FAIL b2b_second_clr: count %0d cycle %0d expected 2/4361", clr_cnt, clr_last); end
    n_chk++; if (busy_after_done !== 0) begin n_fail++; $display("FAIL b2b_idle_gap: busy %0d after done expected 0", busy_after_done); end
  endtask

  task automatic test_abort();
    do_reset(); no_hold(); sel = 0;
    run_pass(1, 1020, 1'b0, 1, 1000);
    n_chk++; if (post_rst_nz !== 0) begin n_fail++; $display("FAIL abort_outputs: %0d nonzero cycles after reset expected 0", post_rst_nz); end
    n_chk++; if (done_cnt !== 0) begin n_fail++; $display("FAIL abort_no_done: %0d pulses expected 0", done_cnt); end
    run_pass(1, 4600, 1'b0, 1, 0);
    n_chk++; if (done_first !== 4359 || tb_cnt !== 256 || sw_cnt !== 4096) begin n_fail++; $display("FAIL abort_rerun: done %0d tb %0d sw %0d expected 4359/256/4096", done_first, tb_cnt, sw_cnt); end
    n_chk++; if (align_err !== 0 || sf_cyc !== 259 || sl_cyc !== 4354) begin n_fail++; $display("FAIL abort_rerun_markers: err %0d first %0d last %0d expected 0/259/4354", align_err, sf_cyc, sl_cyc); end
  endtask

  task automatic test_small();
    do_reset(); no_hold(); sel = 2;
    run_pass(1, 60, 1'b1, 2, 0);
    n_chk++; if (done_first !== 15) begin n_fail++; $display("FAIL small_done: cycle %0d expected 15", done_first); end
    n_chk++; if (tb_first !== 2 || sw_first_c !== 6) begin n_fail++; $display("FAIL small_phases: en_tb from %0d en_sw from %0d expected 2/6", tb_first, sw_first_c); end
    n_chk++; if (done_last !== 31 || tb_cnt !== 8 || sw_cnt !== 16) begin n_fail++; $display("FAIL small_wrap: second done %0d tb %0d sw %0d expected 31/8/16", done_last, tb_cnt, sw_cnt); end
    n_chk++; if (sf_cyc !== 7 || sl_cyc !== 14 || sf_cnt !== 2 || sl_cnt !== 2) begin n_fail++; $display("FAIL small_markers: first %0d last %0d counts %0d/%0d expected 7/14 2/2", sf_cyc, sl_cyc, sf_cnt, sl_cnt); end
    n_chk++; if (align_err !== 0 || overlap !== 0) begin n_fail++; $display("FAIL small_align: err %0d overlap %0d expected 0/0", align_err, overlap); end
  endtask

  initial begin
    sel = 0;
    no_hold();
    test_reset();
    test_nominal();
    test_mem_lat3();
    test_hold();
    test_back_to_back();
    test_abort();
    test_small();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
